// File: rtl/freq_synth.sv
// Frequency synthesiser: a phase accumulator adds the current increment every
// cycle and emits a one-cycle ce pulse on each carry. The applied increment
// either jumps to a new target at once or slews towards it in bounded steps on
// a periodic tick, and the block reports whether it is slewing or locked.
//
// ACC_WIDTH must be greater than WIDTH so the increment fits inside the
// accumulator. WIDTH is assumed to be below 32.

module freq_synth #(
   parameter int unsigned WIDTH     = 12,
   parameter int unsigned ACC_WIDTH = 16,
   parameter int unsigned SLEW_STEP = 0,
   parameter int unsigned SLEW_LOG  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             set,
   input  logic [WIDTH-1:0] din,
   output logic             ce,
   output logic [WIDTH-1:0] cur,
   output logic             locked,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE,
      SLEW,
      LOCK
   } state_t;

   // A step larger than the whole increment range behaves like the range itself.
   localparam int unsigned STEP_MAX = (32'd1 << WIDTH) - 32'd1;
   localparam int unsigned STEP_SAT = (SLEW_STEP > STEP_MAX) ? STEP_MAX : SLEW_STEP;
   localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP_SAT);

   // A zero-length tick period still needs a one-bit counter to exist.
   localparam int unsigned TICK_W = (SLEW_LOG == 0) ? 1 : SLEW_LOG;

   state_t               state;
   state_t               state_next;
   logic [WIDTH-1:0]     target;
   logic [ACC_WIDTH-1:0] acc;
   logic [TICK_W-1:0]    tick;

   logic                 running;
   logic                 tick_wrap;
   logic [ACC_WIDTH:0]   sum;
   logic                 step_up;
   logic [WIDTH-1:0]     step_mag;
   logic [WIDTH-1:0]     step_delta;
   logic [WIDTH-1:0]     cur_step;
   logic [WIDTH-1:0]     cur_next;

   // The accumulator only advances once the block has left IDLE and en is still high.
   assign running   = (state != IDLE) && en;
   assign tick_wrap = (SLEW_LOG == 0) ? 1'b1 : (&tick);

   // Accumulator sum with the carry kept in the top bit.
   always_comb begin
      sum = {1'b0, acc} + (ACC_WIDTH + 1)'(cur);
   end

   // One bounded slew step towards the target; the step never exceeds the gap,
   // so cur cannot overshoot or wrap past either end of its range.
   always_comb begin
      step_up    = (target > cur);
      step_mag   = step_up ? (target - cur) : (cur - target);
      step_delta = (step_mag < STEP_V) ? step_mag : STEP_V;
      cur_step   = step_up ? (cur + step_delta) : (cur - step_delta);
   end

   // Choose the next applied increment: immediate load or a step on each tick.
   always_comb begin
      cur_next = cur;
      if (running && (cur != target)) begin
         if (SLEW_STEP == 0) begin
            cur_next = target;
         end else if (tick_wrap) begin
            cur_next = cur_step;
         end
      end
   end

   // Next state depends only on en and whether cur has caught up with target.
   always_comb begin
      state_next = IDLE;
      if (en) begin
         state_next = (cur == target) ? LOCK : SLEW;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Target, increment, accumulator, tick counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         target <= '0;
         cur    <= '0;
         acc    <= '0;
         tick   <= '0;
         ce     <= 1'b0;
         locked <= 1'b0;
         busy   <= 1'b0;
      end else begin
         if (set) begin
            target <= din;
         end
         cur <= cur_next;
         if (running) begin
            acc  <= sum[ACC_WIDTH-1:0];
            ce   <= sum[ACC_WIDTH];
            tick <= tick + 1'b1;
         end else begin
            acc  <= '0;
            ce   <= 1'b0;
            tick <= '0;
         end
         locked <= (state_next == LOCK);
         busy   <= (state_next == SLEW);
      end
   end

endmodule

// File: tb/tb_freq_synth.sv
// Testbench for freq_synth. Two instances share one clock: an immediate-load
// instance with a 12-bit accumulator (carry rates scale with 2^ACC_WIDTH, so
// 256 here plays the role of 4096 with a 16-bit accumulator) and a slewing
// instance with a 16-bit accumulator, step 16 and a 16-cycle tick.

module tb_freq_synth;

   localparam int IW = 10;
   localparam int IA = 12;
   localparam int IS = 0;
   localparam int IL = 4;
   localparam int SW = 12;
   localparam int SA = 16;
   localparam int SS = 16;
   localparam int SL = 4;

   localparam int M_IDLE = 0;
   localparam int M_SLEW = 1;
   localparam int M_LOCK = 2;

   typedef struct {
      bit rst;
      bit en;
      bit set;
      int din;
   } stim_t;

   typedef struct {
      int     mode;
      int     target;
      int     cur;
      longint acc;
      int     tick;
      bit     ce;
   } model_t;

   typedef struct {
      bit          ce;
      logic [15:0] cur;
      bit          locked;
      bit          busy;
   } exp_t;

   logic clk = 1'b0;

   logic          rst_i, en_i, set_i;
   logic [IW-1:0] din_i;
   logic          ce_i;
   logic [IW-1:0] cur_i;
   logic          locked_i, busy_i;

   logic          rst_s, en_s, set_s;
   logic [SW-1:0] din_s;
   logic          ce_s;
   logic [SW-1:0] cur_s;
   logic          locked_s, busy_s;

   int     total = 0;
   int     bad = 0;
   int     ce_cnt_i = 0;
   exp_t   q_i[$];
   exp_t   q_s[$];
   model_t m_i;
   model_t m_s;

   freq_synth #(.WIDTH(IW), .ACC_WIDTH(IA), .SLEW_STEP(IS), .SLEW_LOG(IL)) dut_imm (
      .clk(clk), .rst(rst_i), .en(en_i), .set(set_i), .din(din_i),
      .ce(ce_i), .cur(cur_i), .locked(locked_i), .busy(busy_i)
   );

   freq_synth #(.WIDTH(SW), .ACC_WIDTH(SA), .SLEW_STEP(SS), .SLEW_LOG(SL)) dut_slew (
      .clk(clk), .rst(rst_s), .en(en_s), .set(set_s), .din(din_s),
      .ce(ce_s), .cur(cur_s), .locked(locked_s), .busy(busy_s)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Reference behaviour for one clock edge, in plain integer arithmetic.
   function automatic model_t modelStep(input model_t m, input stim_t s, input int width,
                                        input int accw, input int step, input int slog);
      model_t n;
      longint sum;
      longint modulus;
      int     gap;
      int     mv;
      bit     tick_now;
      n = m;
      modulus = longint'(1) << accw;
      if (s.rst) begin
         n.mode = M_IDLE; n.target = 0; n.cur = 0; n.acc = 0; n.tick = 0; n.ce = 0;
         return n;
      end
      if (m.mode != M_IDLE && s.en) begin
         sum      = m.acc + longint'(m.cur);
         n.ce     = (sum >= modulus);
         n.acc    = sum % modulus;
         tick_now = (m.tick == (1 << slog) - 1);
         n.tick   = (m.tick + 1) % (1 << slog);
         if (m.cur != m.target) begin
            if (step == 0) begin
               n.cur = m.target;
            end else if (tick_now) begin
               gap   = (m.target > m.cur) ? m.target - m.cur : m.cur - m.target;
               mv    = (gap < step) ? gap : step;
               n.cur = (m.target > m.cur) ? m.cur + mv : m.cur - mv;
            end
         end
      end else begin
         n.acc = 0; n.ce = 0; n.tick = 0;
      end
      if (!s.en) n.mode = M_IDLE;
      else n.mode = (m.cur == m.target) ? M_LOCK : M_SLEW;
      if (s.set) n.target = s.din % (1 << width);
      return n;
   endfunction

   function automatic exp_t toExp(input model_t m);
      exp_t e;
      e.ce     = m.ce;
      e.cur    = 16'(m.cur);
      e.locked = (m.mode == M_LOCK);
      e.busy   = (m.mode == M_SLEW);
      return e;
   endfunction

   function automatic stim_t mk(input bit r, input bit e, input bit s, input int d);
      stim_t t;
      t.rst = r; t.en = e; t.set = s; t.din = d;
      return t;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s @%0t: got %0d, want %0d", name, $time, actual, expected);
      end
   endtask

   task automatic compareOut(input string name, input exp_t e, input logic ce, input logic [15:0] cur,
                             input logic locked, input logic busy);
      total++;
      if (ce !== e.ce || cur !== e.cur || locked !== e.locked || busy !== e.busy) begin
         bad++;
         $display("[TB] FAIL %s @%0t: got ce=%b cur=%0d locked=%b busy=%b, want ce=%b cur=%0d locked=%b busy=%b",
                  name, $time, ce, cur, locked, busy, e.ce, e.cur, e.locked, e.busy);
      end
   endtask

   // Drive one cycle on both instances, queue the predicted outputs, cross the edge.
   task automatic applyStimulus(input stim_t a, input stim_t b);
      rst_i = a.rst; en_i = a.en; set_i = a.set; din_i = IW'(a.din);
      rst_s = b.rst; en_s = b.en; set_s = b.set; din_s = SW'(b.din);
      m_i = modelStep(m_i, a, IW, IA, IS, IL);
      q_i.push_back(toExp(m_i));
      m_s = modelStep(m_s, b, SW, SA, SS, SL);
      q_s.push_back(toExp(m_s));
      @(posedge clk);
      #1;
   endtask

   // Monitor: after every edge pop the predicted outputs and compare.
   always @(posedge clk) begin : monitor
      exp_t e;
      #2;
      if (q_i.size() > 0) begin
         e = q_i.pop_front();
         compareOut("imm_cycle", e, ce_i, 16'(cur_i), locked_i, busy_i);
      end
      if (q_s.size() > 0) begin
         e = q_s.pop_front();
         compareOut("slew_cycle", e, ce_s, 16'(cur_s), locked_s, busy_s);
      end
      if (ce_i === 1'b1) ce_cnt_i++;
   end

   // Watchdog so the run always ends.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: got timeout, want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios followed by randomized traffic.
   initial begin
      stim_t run_i, run_s;
      int    prev, nsteps, last_c, min_cur;
      bit    en_ri, en_rs;
      m_i = '{M_IDLE, 0, 0, 0, 0, 0};
      m_s = '{M_IDLE, 0, 0, 0, 0, 0};
      run_i = mk(0, 1, 0, 0);
      run_s = mk(0, 1, 0, 0);

      // Reset state.
      repeat (2) applyStimulus(mk(1, 0, 0, 0), mk(1, 0, 0, 0));
      checkOutput("reset_cur", 32'(cur_i), 0);
      checkOutput("reset_ce", 32'(ce_i), 0);
      checkOutput("reset_locked", 32'(locked_i), 0);
      checkOutput("reset_busy", 32'(busy_s), 0);

      // Enable at cur == target == 0 gives LOCK with no carries.
      repeat (3) applyStimulus(run_i, run_s);
      checkOutput("lock_at_zero", 32'(locked_i), 1);

      // Immediate load: cur follows two cycles after set, then ce every 16 cycles.
      applyStimulus(mk(0, 1, 1, 256), run_s);
      checkOutput("imm_load_not_early", 32'(cur_i), 0);
      applyStimulus(run_i, run_s);
      checkOutput("imm_load_2cyc", 32'(cur_i), 256);
      repeat (4) applyStimulus(run_i, run_s);
      ce_cnt_i = 0;
      repeat (64) applyStimulus(run_i, run_s);
      checkOutput("imm_ce_per_64", 32'(ce_cnt_i), 4);
      checkOutput("imm_locked", 32'(locked_i), 1);

      // Increment 1: exactly one carry per 2^ACC_WIDTH cycles.
      applyStimulus(mk(0, 1, 1, 1), run_s);
      repeat (3) applyStimulus(run_i, run_s);
      ce_cnt_i = 0;
      repeat (8192) applyStimulus(run_i, run_s);
      checkOutput("imm_ce_din1", 32'(ce_cnt_i), 2);

      // Increment 0: no carries at all.
      applyStimulus(mk(0, 1, 1, 0), run_s);
      repeat (3) applyStimulus(run_i, run_s);
      ce_cnt_i = 0;
      repeat (8192) applyStimulus(run_i, run_s);
      checkOutput("imm_ce_din0", 32'(ce_cnt_i), 0);

      // Dropping en in LOCK: no ce, cur kept; resuming restarts from a clear accumulator.
      applyStimulus(mk(0, 1, 1, 256), run_s);
      repeat (4) applyStimulus(run_i, run_s);
      applyStimulus(mk(0, 0, 0, 0), run_s);
      ce_cnt_i = 0;
      repeat (40) applyStimulus(mk(0, 0, 0, 0), run_s);
      checkOutput("idle_no_ce", 32'(ce_cnt_i), 0);
      checkOutput("idle_cur_kept", 32'(cur_i), 256);
      checkOutput("idle_unlocked", 32'(locked_i), 0);
      repeat (40) applyStimulus(run_i, run_s);

      // Slew 0 -> 64 in steps of 16, one per tick, locked the cycle after arrival.
      applyStimulus(run_i, mk(0, 1, 1, 64));
      prev = 32'(cur_s); nsteps = 0; last_c = 0;
      for (int c = 0; c < 80; c++) begin
         applyStimulus(run_i, run_s);
         if (nsteps == 4 && c == last_c + 1) checkOutput("slew_lock_next", 32'(locked_s), 1);
         if (32'(cur_s) != prev) begin
            nsteps++;
            checkOutput("slew_step_value", 32'(cur_s), 32'(16 * nsteps));
            checkOutput("slew_busy", 32'(busy_s), 1);
            if (nsteps > 1) checkOutput("slew_step_gap", 32'(c - last_c), 16);
            last_c = c;
            prev = 32'(cur_s);
         end
      end
      checkOutput("slew_nsteps", 32'(nsteps), 4);
      checkOutput("slew_final_locked", 32'(locked_s), 1);

      // Retarget mid-slew: 64 -> 10, then 40 after the first step; no overshoot.
      applyStimulus(run_i, mk(0, 1, 1, 10));
      for (int c = 0; c < 40 && m_s.cur != 48; c++) applyStimulus(run_i, run_s);
      checkOutput("slew_reach_48", 32'(cur_s), 48);
      applyStimulus(run_i, mk(0, 1, 1, 40));
      min_cur = 48;
      for (int c = 0; c < 40; c++) begin
         applyStimulus(run_i, run_s);
         if (32'(cur_s) < min_cur) min_cur = 32'(cur_s);
      end
      checkOutput("slew_no_overshoot", 32'(min_cur), 40);
      checkOutput("slew_retarget_cur", 32'(cur_s), 40);
      checkOutput("slew_retarget_locked", 32'(locked_s), 1);

      // Reset while slewing with a carry about to be reported.
      applyStimulus(run_i, mk(0, 1, 1, 4095));
      for (int c = 0; c < 6000 && !(m_s.mode == M_SLEW && m_s.acc + m_s.cur >= 65536); c++)
         applyStimulus(run_i, run_s);
      checkOutput("rst_pre_busy", 32'(busy_s), 1);
      applyStimulus(run_i, mk(1, 1, 1, 77));
      checkOutput("rst_ce", 32'(ce_s), 0);
      checkOutput("rst_cur", 32'(cur_s), 0);
      checkOutput("rst_locked", 32'(locked_s), 0);
      checkOutput("rst_busy", 32'(busy_s), 0);

      // Randomized traffic on both instances.
      en_ri = 1'b1; en_rs = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 49) == 0) en_ri = !en_ri;
         if ($urandom_range(0, 49) == 0) en_rs = !en_rs;
         applyStimulus(mk($urandom_range(0, 199) == 0, en_ri, $urandom_range(0, 29) == 0,
                          int'($urandom_range(0, 1023))),
                       mk($urandom_range(0, 199) == 0, en_rs, $urandom_range(0, 29) == 0,
                          int'($urandom_range(0, 4095))));
      end

      #5;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
